// File: rtl/spi_tx_sched_pkg.sv
// ============================================================================
//  Module      : spi_tx_sched_pkg
//  Description : Shared types and helpers for the SPI transmit scheduler.
//                The state encoding, the default header magic nibble and the
//                header-byte assembly function live here.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_tx_sched_pkg;

    // Scheduler states. The encoding is fixed at two bits.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CSUM    = 2'd3
    } state_t;

    // Default upper nibble of every header byte.
    localparam logic [3:0] c_hdr_magic_def = 4'hA;

    // A header byte carries the magic nibble and the source index.
    function automatic logic [7:0] make_hdr(input logic [3:0] magic,
                                            input logic [3:0] src);
        return {magic, src};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_tx_scheduler_rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first active
//                request at or after ptr, wrapping at N. The caller registers
//                the result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          enable,
    output logic [PW-1:0] grant,
    output logic          grant_valid
);

    localparam logic [PW:0] c_n = (PW+1)'(N);

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        logic [PW:0] w_sum;
        grant       = '0;
        grant_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            w_sum = {1'b0, ptr} + (PW+1)'(i);
            if (w_sum >= c_n) begin
                w_sum = w_sum - c_n;
            end
            if (enable && req[w_sum[PW-1:0]]) begin
                grant       = w_sum[PW-1:0];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_tx_scheduler.sv
// ============================================================================
//  Module      : spi_tx_scheduler
//  Description : Packet-level round-robin scheduler feeding an 8-bit
//                valid/ready byte sink from NUM_SRC telemetry sources. Each
//                packet is prefixed by {HDR_MAGIC, source index}; payloads
//                longer than MAX_LEN are cut and resume on a later grant.
//                Optional macro SPI_TX_SCHED_CSUM_EN appends an XOR checksum
//                byte over the header and payload bytes of each packet.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_tx_scheduler
    import spi_tx_sched_pkg::*;
#(
    parameter int         NUM_SRC   = 4,
    parameter logic [3:0] HDR_MAGIC = c_hdr_magic_def,
    parameter int         MAX_LEN   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [NUM_SRC*8-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [3:0]           cur_src
);

    localparam int             PW         = $clog2(NUM_SRC);
    localparam logic [PW-1:0]  c_last_src = PW'(NUM_SRC - 1);
    localparam logic [7:0]     c_last_cnt = 8'(MAX_LEN - 1);

    state_t        r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_gnt;
    logic [7:0]    r_cnt;
    logic [7:0]    r_hdr;
`ifdef SPI_TX_SCHED_CSUM_EN
    logic [7:0]    r_xor;
`endif

    logic [PW-1:0] w_grant;
    logic          w_grant_valid;
    logic [7:0]    w_src_byte [NUM_SRC];
    logic          w_sel_valid;
    logic          w_sel_last;
    logic [7:0]    w_sel_data;
    logic          w_xfer;

    // Unpack the flat source data bus into per-source bytes.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
        assign w_src_byte[gi] = src_data[8*gi +: 8];
    end

    rr_arbiter #(
        .N  (NUM_SRC),
        .PW (PW)
    ) u_arb (
        .req         (src_valid),
        .ptr         (r_ptr),
        .enable      (r_state == ST_IDLE),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    assign w_sel_valid = src_valid[r_gnt];
    assign w_sel_last  = src_last[r_gnt];
    assign w_sel_data  = w_src_byte[r_gnt];
    assign w_xfer      = (r_state == ST_PAYLOAD) && w_sel_valid && out_ready;
    assign busy        = (r_state != ST_IDLE);
    assign cur_src     = 4'(r_gnt);

    // Packet sequencing: grant, header, payload passthrough, optional checksum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_cnt   <= 8'h00;
            r_hdr   <= 8'h00;
`ifdef SPI_TX_SCHED_CSUM_EN
            r_xor   <= 8'h00;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_gnt   <= w_grant;
                        r_hdr   <= make_hdr(HDR_MAGIC, 4'(w_grant));
                        r_ptr   <= (w_grant == c_last_src) ? '0 : w_grant + PW'(1);
                        r_state <= ST_HDR;
`ifdef SPI_TX_SCHED_CSUM_EN
                        r_xor   <= 8'h00;
`endif
                    end
                end
                ST_HDR: begin
                    if (out_ready) begin
                        r_cnt   <= 8'h00;
                        r_state <= ST_PAYLOAD;
`ifdef SPI_TX_SCHED_CSUM_EN
                        r_xor   <= r_hdr;
`endif
                    end
                end
                ST_PAYLOAD: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt + 8'd1;
`ifdef SPI_TX_SCHED_CSUM_EN
                        r_xor <= r_xor ^ w_sel_data;
`endif
                        // A marked last byte or the MAX_LEN-th byte closes the packet.
                        if (w_sel_last || (r_cnt == c_last_cnt)) begin
`ifdef SPI_TX_SCHED_CSUM_EN
                            r_state <= ST_CSUM;
`else
                            r_state <= ST_IDLE;
`endif
                        end
                    end
                end
`ifdef SPI_TX_SCHED_CSUM_EN
                ST_CSUM: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output steering: registered header/checksum, passthrough during payload.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        src_ready = '0;
        case (r_state)
            ST_HDR: begin
                out_valid = 1'b1;
                out_data  = r_hdr;
            end
            ST_PAYLOAD: begin
                out_valid        = w_sel_valid;
                out_data         = w_sel_valid ? w_sel_data : 8'h00;
                src_ready[r_gnt] = out_ready;
            end
`ifdef SPI_TX_SCHED_CSUM_EN
            ST_CSUM: begin
                out_valid = 1'b1;
                out_data  = r_xor;
            end
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_tx_scheduler.sv
// ============================================================================
//  Module      : tb_spi_tx_scheduler
//  Description : Self-checking bench for spi_tx_scheduler. Per-source packet
//                queues feed the DUT; a transaction-level model predicts the
//                byte stream, handshakes and grant order.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_tx_scheduler;

    localparam int         NUM_SRC   = 4;
    localparam int         MAX_LEN   = 4;
    localparam logic [3:0] HDR_MAGIC = 4'hA;
`ifdef SPI_TX_SCHED_CSUM_EN
    localparam int         CSUM      = 1;
`else
    localparam int         CSUM      = 0;
`endif

    typedef logic [7:0] bq_t[$];

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NUM_SRC-1:0]   src_valid;
    logic [NUM_SRC*8-1:0] src_data;
    logic [NUM_SRC-1:0]   src_last;
    logic [NUM_SRC-1:0]   src_ready;
    logic                 out_valid;
    logic [7:0]           out_data;
    logic                 out_ready;
    logic                 busy;
    logic [3:0]           cur_src;

    spi_tx_scheduler #(
        .NUM_SRC   (NUM_SRC),
        .HDR_MAGIC (HDR_MAGIC),
        .MAX_LEN   (MAX_LEN)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_last  (src_last),
        .src_ready (src_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .cur_src   (cur_src)
    );

    always #5 clk = ~clk;

    // Per-source pending bytes: bit 8 is the last-of-packet flag.
    logic [8:0] q [NUM_SRC][$];

    // Transaction model: phase 0 idle, 1 header, 2 payload, 3 checksum.
    int         m_phase = 0;
    int         m_ptr   = 0;
    int         m_gnt   = 0;
    int         m_cnt   = 0;
    logic [7:0] m_xor   = 8'h00;

    int   vld_pct  = 100;
    int   rdy_mode = 0;
    int   cyc      = 0;
    int   n_pass   = 0;
    int   n_total  = 0;
    int   busy_cycles;
    int   rdy1_cycles;
    bq_t  hdr_log;
    bq_t  stream;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic add_pkt(input int s, input bq_t bytes);
        for (int i = 0; i < bytes.size(); i++)
            q[s].push_back({(i == bytes.size() - 1), bytes[i]});
    endtask

    task automatic check_stream(input string tag, input bq_t exp);
        check_val({tag, "_len"}, stream.size(), exp.size());
        for (int i = 0; i < exp.size() && i < stream.size(); i++)
            check_val($sformatf("%s_b%0d", tag, i), stream[i], exp[i]);
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step();
        logic [NUM_SRC-1:0] e_rdy;
        logic               e_vld;
        logic [7:0]         e_dat;
        logic [8:0]         b;
        bit                 hs;
        bit                 found;
        int                 idx;
        @(negedge clk);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (q[i].size() > 0) begin
                src_valid[i] = ($urandom_range(99) < vld_pct);
                b = q[i][0];
                src_last[i] = b[8];
                src_data[i*8 +: 8] = b[7:0];
            end else begin
                src_valid[i] = 1'b0;
                src_last[i] = 1'($urandom_range(1));
                src_data[i*8 +: 8] = 8'($urandom);
            end
        end
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(99) < 60);
            default: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        endcase
        cyc++;
        #1;
        e_rdy = '0;
        e_vld = 1'b0;
        e_dat = 8'h00;
        case (m_phase)
            1: begin e_vld = 1'b1; e_dat = {HDR_MAGIC, 4'(m_gnt)}; end
            2: begin
                e_vld = src_valid[m_gnt];
                if (e_vld) begin b = q[m_gnt][0]; e_dat = b[7:0]; end
                e_rdy[m_gnt] = out_ready;
            end
            3: begin e_vld = 1'b1; e_dat = m_xor; end
            default: ;
        endcase
        check_val("out_valid", out_valid, e_vld);
        check_val("out_data", out_data, e_dat);
        check_val("src_ready", src_ready, e_rdy);
        check_val("busy", busy, (m_phase != 0));
        check_val("cur_src", cur_src, 4'(m_gnt));
        if (out_valid && out_ready) stream.push_back(out_data);
        if (busy) busy_cycles++;
        if (src_ready[1]) rdy1_cycles++;
        hs = e_vld && out_ready;
        case (m_phase)
            0: begin
                found = 1'b0;
                for (int k = 0; k < NUM_SRC; k++) begin
                    idx = (m_ptr + k) % NUM_SRC;
                    if (!found && src_valid[idx]) begin found = 1'b1; m_gnt = idx; end
                end
                if (found) begin
                    m_ptr   = (m_gnt + 1) % NUM_SRC;
                    m_phase = 1;
                    hdr_log.push_back({HDR_MAGIC, 4'(m_gnt)});
                end
            end
            1: if (hs) begin m_xor = e_dat; m_cnt = 0; m_phase = 2; end
            2: if (hs) begin
                b = q[m_gnt].pop_front();
                m_xor ^= b[7:0];
                m_cnt++;
                if (b[8] || m_cnt == MAX_LEN) m_phase = (CSUM != 0) ? 3 : 0;
            end
            3: if (hs) m_phase = 0;
            default: ;
        endcase
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int n;
        bit pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < max_cyc) begin
            step();
            n++;
            pending = (m_phase != 0);
            for (int i = 0; i < NUM_SRC; i++) if (q[i].size() > 0) pending = 1'b1;
        end
        check_val({tag, "_done"}, !pending, 1);
    endtask

    // Reset just after an edge so the model never loses a transfer.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        src_valid = '0;
        reset_n   = 1'b0;
        #1;
        check_val({tag, "_out_valid"}, out_valid, 0);
        check_val({tag, "_out_data"}, out_data, 0);
        check_val({tag, "_src_ready"}, src_ready, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_cur_src"}, cur_src, 0);
        m_phase = 0;
        m_ptr   = 0;
        m_gnt   = 0;
        m_xor   = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bq_t e;
        bq_t p;
        int  n;
        reset_n   = 1'b0;
        src_valid = '0;
        src_data  = '0;
        src_last  = '0;
        out_ready = 1'b1;
        hdr_log   = {};
        stream    = {};

        // Power-on reset.
        do_reset("rst0");

        // Single 3-byte packet from source 1.
        busy_cycles = 0;
        rdy1_cycles = 0;
        add_pkt(1, '{8'h11, 8'h22, 8'h33});
        drain("single", 50);
        e = '{8'hA1, 8'h11, 8'h22, 8'h33};
        if (CSUM != 0) e.push_back(8'hA1);
        check_stream("single", e);
        check_val("single_busy_cycles", busy_cycles, 4 + CSUM);
        check_val("single_rdy1_cycles", rdy1_cycles, 3);

        // Round-robin between sources 0 and 2, two packets each, from reset.
        do_reset("rst1");
        hdr_log = {};
        add_pkt(0, '{8'h01, 8'h02});
        add_pkt(0, '{8'h03, 8'h04});
        add_pkt(2, '{8'h21, 8'h22});
        add_pkt(2, '{8'h23, 8'h24});
        drain("rr", 100);
        e = '{8'hA0, 8'hA2, 8'hA0, 8'hA2};
        check_val("rr_hdr_count", hdr_log.size(), 4);
        for (int i = 0; i < 4 && i < hdr_log.size(); i++)
            check_val($sformatf("rr_hdr%0d", i), hdr_log[i], e[i]);

        // Backpressure with out_ready pattern 1,0,0,1.
        rdy_mode = 2;
        stream = {};
        add_pkt(0, '{8'h5A, 8'h5B, 8'h5C});
        drain("bp", 100);
        e = '{8'hA0, 8'h5A, 8'h5B, 8'h5C};
        if (CSUM != 0) e.push_back(8'hFD);
        check_stream("bp", e);
        rdy_mode = 0;

        // Truncation at MAX_LEN=4: six bytes split into two packets.
        stream  = {};
        hdr_log = {};
        add_pkt(3, '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36});
        drain("trunc", 100);
        e = '{8'hA3, 8'h31, 8'h32, 8'h33, 8'h34};
        if (CSUM != 0) e.push_back(8'hA7);
        e.push_back(8'hA3);
        e.push_back(8'h35);
        e.push_back(8'h36);
        if (CSUM != 0) e.push_back(8'hA0);
        check_stream("trunc", e);
        check_val("trunc_hdr_count", hdr_log.size(), 2);

        // Two-byte packet: checksum byte when enabled, else stream ends at 0x22.
        stream = {};
        add_pkt(1, '{8'h11, 8'h22});
        drain("csum", 50);
        e = '{8'hA1, 8'h11, 8'h22};
        if (CSUM != 0) e.push_back(8'h92);
        check_stream("csum", e);

        // Reset after the second payload byte of a source-2 packet.
        add_pkt(2, '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45});
        n = 0;
        while (!(m_phase == 2 && m_cnt == 2) && n < 20) begin
            step();
            n++;
        end
        check_val("midrst_reached", (m_phase == 2 && m_cnt == 2), 1);
        do_reset("midrst");
        hdr_log = {};
        add_pkt(3, '{8'h51, 8'h52});
        drain("midrst", 100);
        check_val("midrst_hdr_count", hdr_log.size(), 2);
        if (hdr_log.size() == 2) begin
            check_val("midrst_hdr0", hdr_log[0], 8'hA2);
            check_val("midrst_hdr1", hdr_log[1], 8'hA3);
        end

        // Randomized traffic with random valid gaps and backpressure.
        vld_pct  = 70;
        rdy_mode = 1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(99) < 8) begin
                int s;
                s = $urandom_range(NUM_SRC - 1);
                if (q[s].size() < 16) begin
                    p = {};
                    n = $urandom_range(7, 1);
                    for (int j = 0; j < n; j++) p.push_back(8'($urandom));
                    add_pkt(s, p);
                end
            end
            step();
        end
        drain("rand", 4000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_tx_scheduler.md
Name: spi_tx_scheduler

Overview:
- Packet-level scheduler feeding the SPI slave's 8-bit Avalon-ST transmit sink (valid/ready/data) from several on-chip telemetry sources: PID focus status, preprocess sync/timing, I2S audio status, and others.
- Round-robin grant at packet boundaries; each packet is prefixed with a header byte that identifies the source.
- Sits between the telemetry producers and the SPI slave sink inside the OVDP system.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..16).
- HDR_MAGIC, 4'hA, upper nibble of every header byte.
- MAX_LEN, 32, maximum payload bytes per grant (1..255); a longer packet is cut at this length.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- src_valid  in  NUM_SRC  per-source byte valid.
- src_data  in  NUM_SRC*8  per-source byte; source i occupies bits [8i+7:8i].
- src_last  in  NUM_SRC  per-source last-byte-of-packet flag.
- src_ready  out  NUM_SRC  per-source byte accepted.
- out_valid  out  1  byte valid to SPI slave sink.
- out_data  out  8  byte to SPI slave sink.
- out_ready  in  1  SPI slave sink ready.
- busy  out  1  high whenever state is not IDLE.
- cur_src  out  4  index of the granted source; held after the packet ends.

Behaviour:
- Reset (async, reset_n=0) forces:
  - State=IDLE, rr pointer=0, byte count=0, cur_src=0.
  - out_valid=0, out_data=0, src_ready=0, busy=0.
- States: IDLE -> HDR -> PAYLOAD -> IDLE. With the optional feature, PAYLOAD -> CSUM -> IDLE.
- IDLE:
  - If any src_valid is high, grant the first requester at or after the rr pointer (wrapping), register it in cur_src, and go to HDR next cycle. Arbitration latency is 1 cycle.
  - Set rr pointer = grant+1 mod NUM_SRC.
  - If no requester is valid, stay in IDLE.
- HDR:
  - out_valid=1, out_data={HDR_MAGIC, cur_src[3:0]} (registered).
  - On out_valid&out_ready, go to PAYLOAD with count=0.
  - out_data is stable while stalled.
- PAYLOAD, combinational passthrough from the granted source:
  - out_valid=src_valid[g], out_data=src_data[g], src_ready[g]=out_ready.
  - All other src_ready are 0.
  - On each transfer (src_valid[g]&out_ready), count increments.
  - Packet ends on a transfer with src_last[g]=1, or on the transfer where count==MAX_LEN-1 (truncation). The source keeps its remaining bytes and re-arbitrates later.
  - src_valid[g] dropping mid-packet just stalls; no timeout.
- src_ready is never asserted outside PAYLOAD. Bytes are never duplicated or dropped.
- out_data=0 whenever out_valid=0 (IDLE).
- Simultaneous requests: the rr pointer decides. A single continuously-requesting source is re-granted back-to-back, with a 1-cycle IDLE gap between packets.
- Requests arriving during HDR/PAYLOAD are ignored until IDLE.
- Reset mid-packet: the packet is abandoned immediately. The SPI host resynchronises on HDR_MAGIC.

Optional Feature:
- Macro SPI_TX_SCHED_CSUM_EN.
- Defined:
  - An 8-bit running XOR is taken over the header and payload bytes actually transferred.
  - After the last payload transfer, go to CSUM: out_valid=1, out_data=xor; on out_ready go to IDLE.
  - The xor register resets to 0 at the start of each HDR.
- Undefined: no CSUM state; PAYLOAD goes directly to IDLE.

Decomposition:
- Package spi_tx_sched_pkg:
  - State enum (IDLE, HDR, PAYLOAD, CSUM).
  - HDR_MAGIC default.
  - Header-byte assembly function.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs req[N], ptr, enable.
  - Outputs grant index and grant_valid, purely combinational.
  - The scheduler registers the result.

Test Plan:
- Single packet: src1 sends 3 bytes 0x11,0x22,0x33 (last on 0x33), out_ready=1 -> out stream 0xA1,0x11,0x22,0x33; busy high 4 cycles; src_ready[1] high only on the 3 payload cycles.
- Round-robin: src0 and src2 both valid with 2-byte packets from reset -> packet order src0 (0xA0...) then src2 (0xA2...); next contention between src0 and src2 grants src0 again (pointer=3 wraps to 0).
- Backpressure: out_ready toggles 1,0,0,1 during HDR and PAYLOAD -> out_data constant while stalled; each byte appears exactly once on out_valid&out_ready.
- Truncation: MAX_LEN=4, src3 sends 6 bytes with last on byte 6 -> 0xA3 + bytes 1..4, IDLE; next grant to src3 sends 0xA3 + bytes 5..6.
- Reset mid-PAYLOAD: assert reset_n=0 after byte 2 -> out_valid, src_ready, busy go 0 asynchronously; after release, the next grant starts with a fresh header and the pointer is 0.
- CSUM (macro defined): src1 sends 0x11,0x22 -> stream 0xA1,0x11,0x22,0x92 (0xA1^0x11^0x22); with the macro undefined, stream ends at 0x22.
